mesh_node_port: RTL and testbench
=================================

# mesh_node_port

Endpoint network interface that sits between a processing node and the local port of its mesh router. It packetises outgoing messages from the node into router flits, and accepts packets ejected by the router back to the node. It is the injector/ejector counterpart of the router's queue/availability protocol, with elastic buffering on both directions.

## Interface
- `PL`, 32: packet (flit) width in bits, MSB-first `[0:PL-1]`.
- `CS`, 2: coordinate width in bits.
- `DEPTH`, 4: entries in each of the TX and RX FIFOs (power of two, ≥2).
- `PW`, derived = `PL-1-4*CS`: payload width.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `node_X`, `node_Y`  in  `CS`  this node's coordinates.
- `tx_valid`  in  1  node offers a message.
- `tx_ready`  out  1  TX FIFO not full.
- `tx_dest_X`, `tx_dest_Y`  in  `CS`  destination.
- `tx_payload`  in  `PW`  message body.
- `to_router`  out  `[0:PL-1]`  flit into the router local input.
- `router_avail`  in  1  router local queue can accept a flit this cycle.
- `from_router`  in  `[0:PL-1]`  flit from the router local output.
- `avail_to_router`  out  1  RX FIFO can accept a flit this cycle.
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  node consumes the head message.
- `rx_src_X`, `rx_src_Y`  out  `CS`  source of the head message.
- `rx_payload`  out  `PW`  body of the head message.
- `misroute`  out  1  sticky: a flit arrived with destination ≠ (`node_X`, `node_Y`).
- `tx_count`, `rx_count`  out  16  flits sent / received, wrapping.

## Operation
- Flit layout: bit 0 = valid; `[1:CS]` dest X; `[CS+1:2CS]` dest Y; `[2CS+1:3CS]` src X; `[3CS+1:4CS]` src Y; `[4CS+1:PL-1]` payload. An all-zero flit means idle.
- TX push: `tx_valid && tx_ready` writes {dest, `node_X`/`node_Y` as src, payload} at the TX tail. Source coordinates are captured at push time.
- TX send: `to_router` carries the TX head with the valid bit set when the FIFO is non-empty and `router_avail`=1. Otherwise `to_router` is all zeros. The head pops in the same cycle, so one flit is sent per cycle at most.
- RX accept: when `from_router[0]`=1 and `avail_to_router`=1, the flit is written at the RX tail. A valid flit arriving while `avail_to_router`=0 is a protocol violation by the sender and is dropped: it is not written and `rx_count` does not increment.
- RX pop: `rx_valid && rx_ready` advances the head. The `rx_*` outputs are combinational from the head entry.
- Misroute: on an accepted flit whose dest ≠ (`node_X`,`node_Y`), `misroute` sets and stays set until `rst`. The flit is still stored.
- Counters: `tx_count` increments per sent flit and `rx_count` per accepted flit. Both wrap from 0xFFFF to 0.
- FIFOs: `DEPTH` entries each, with read/write pointers of log2(`DEPTH`)+1 bits. Full = pointers differ only in the MSB. Simultaneous push and pop when full: the push is refused, because ready/avail are computed before the pop. Simultaneous push and pop when non-empty and not full: both occur and the occupancy is unchanged.

## Timing
- Reset (sync, on the `clk` edge with `rst`=1): FIFOs empty, counters 0, `misroute` 0. In the cycle after reset: `tx_ready`=1, `avail_to_router`=1, `rx_valid`=0, `to_router`=0.
- `rst` asserted mid-operation discards all buffered flits. `to_router` is 0 from the next cycle.
- TX latency: a message pushed at edge N can appear on `to_router` in cycle N+1 (after that edge), if `router_avail` is high.
- `to_router` is combinational from `router_avail` and the FIFO state. No combinational path exists from `tx_valid` to `to_router`.
- RX latency: a flit accepted at edge N gives `rx_valid`=1 in cycle N+1.
- `avail_to_router` and `tx_ready` depend only on registered state, never on same-cycle pops.
- Throughput: 1 flit/cycle in each direction, sustained.

## Test plan
- Reset, then push 1 message (dest 2,1; payload 0x5A) with `router_avail`=1 at `node`=(0,0) -> next cycle `to_router` shows valid=1, dest (2,1), src (0,0), payload 0x5A; `tx_count`=1; `to_router`=0 the following cycle.
- Hold `router_avail`=0 and push 5 messages (`DEPTH`=4) -> `tx_ready` drops after the 4th; the 5th is not accepted. Then raise `router_avail` -> 4 flits go out on consecutive cycles in FIFO order, and `tx_ready` reasserts after the first send.
- Inject 4 flits addressed to (1,1) at node (1,1) with `rx_ready`=0 -> `avail_to_router`=0 after the 4th. A 5th valid flit is dropped and `rx_count`=4. Pop all 4 -> payloads match in order.
- Simultaneous RX push and pop at occupancy 2 for 10 cycles -> occupancy stays 2, `rx_count` advances by 10.
- Accept a flit with dest (0,2) at node (1,0) -> `misroute`=1, the flit is delivered on `rx_*`, and `misroute` stays 1 until `rst`.
- Fill both FIFOs, assert `rst` for one cycle -> all outputs at reset values next cycle; `tx_count` wraps 0xFFFF->0 after 65536 sends in a long run.

Source files
------------

// File: rtl/mesh_node_port.sv
// mesh_node_port: packetises node messages into router flits and buffers ejected flits back to the node.
module mesh_node_port #(
  parameter int PL = 32,
  parameter int CS = 2,
  parameter int DEPTH = 4,
  parameter int PW = PL - 1 - 4 * CS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CS-1:0] node_X,
  input  logic [CS-1:0] node_Y,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [CS-1:0] tx_dest_X,
  input  logic [CS-1:0] tx_dest_Y,
  input  logic [PW-1:0] tx_payload,
  output logic [0:PL-1] to_router,
  input  logic          router_avail,
  input  logic [0:PL-1] from_router,
  output logic          avail_to_router,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CS-1:0] rx_src_X,
  output logic [CS-1:0] rx_src_Y,
  output logic [PW-1:0] rx_payload,
  output logic          misroute,
  output logic [15:0]   tx_count,
  output logic [15:0]   rx_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * CS + PW;
  logic [PL-2:0] tx_mem [DEPTH];
  logic [RW-1:0] rx_mem [DEPTH];
  logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_push, tx_send, rx_push, rx_pop;
  // Full when pointers differ only in the wrap bit; flags come from registered pointers only
  assign tx_ready = (tx_wp ^ tx_rp) != {1'b1, {AW{1'b0}}};
  assign avail_to_router = (rx_wp ^ rx_rp) != {1'b1, {AW{1'b0}}};
  assign rx_valid = rx_wp != rx_rp;
  assign tx_push = tx_valid && tx_ready;
  assign tx_send = (tx_wp != tx_rp) && router_avail;
  assign rx_push = from_router[0] && avail_to_router;
  assign rx_pop = rx_valid && rx_ready;
  assign to_router = tx_send ? {1'b1, tx_mem[tx_rp[AW-1:0]]} : '0;
  assign {rx_src_X, rx_src_Y, rx_payload} = rx_mem[rx_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= {tx_dest_X, tx_dest_Y, node_X, node_Y, tx_payload};
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= from_router[2*CS+1:PL-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      tx_count <= '0;
      rx_count <= '0;
      misroute <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_send) tx_rp <= tx_rp + 1'b1;
      if (tx_send) tx_count <= tx_count + 16'd1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_push) rx_count <= rx_count + 16'd1;
      if (rx_push && (from_router[1:CS] != node_X || from_router[CS+1:2*CS] != node_Y)) misroute <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mesh_node_port.sv
// tb_mesh_node_port: vector tables and directed sequences checked against a queue-based scoreboard.
module tb_mesh_node_port;
  localparam int PL = 32, CS = 2, DEPTH = 4, PW = PL - 1 - 4 * CS;
  logic clk = 1'b0, rst = 1'b1;
  logic [CS-1:0] node_X = '0, node_Y = '0, tx_dest_X = '0, tx_dest_Y = '0, rx_src_X, rx_src_Y;
  logic tx_valid = 1'b0, tx_ready, router_avail = 1'b0, avail_to_router, rx_valid, rx_ready = 1'b0, misroute;
  logic [PW-1:0] tx_payload = '0, rx_payload;
  logic [0:PL-1] to_router, from_router = '0;
  logic [15:0] tx_count, rx_count;

  mesh_node_port #(.PL(PL), .CS(CS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .node_X(node_X), .node_Y(node_Y),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest_X(tx_dest_X), .tx_dest_Y(tx_dest_Y),
    .tx_payload(tx_payload), .to_router(to_router), .router_avail(router_avail),
    .from_router(from_router), .avail_to_router(avail_to_router), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_src_X(rx_src_X), .rx_src_Y(rx_src_Y), .rx_payload(rx_payload),
    .misroute(misroute), .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:PL-1] mk(input logic [CS-1:0] dx, dy, sx, sy, input logic [PW-1:0] pl);
    return {1'b1, dx, dy, sx, sy, pl};
  endfunction

  // Scoreboard: expected flits/messages queued on acceptance, compared when presented
  logic [PL-1:0] tx_q[$];
  logic [2*CS+PW-1:0] rx_q[$];
  logic [15:0] m_tx = '0, m_rx = '0;
  logic m_mis = 1'b0;
  bit mon = 0, snd, tacc, racc, rpop;
  always @(negedge clk) if (mon) begin
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      m_tx = '0;
      m_rx = '0;
      m_mis = 1'b0;
    end else begin
      snd = tx_q.size() > 0 && router_avail;
      tacc = tx_valid && tx_q.size() < DEPTH;
      chk("sb_tx_ready", tx_ready, tx_q.size() < DEPTH);
      chk("sb_to_router", to_router, snd ? tx_q[0] : '0);
      chk("sb_tx_count", tx_count, m_tx);
      racc = from_router[0] && rx_q.size() < DEPTH;
      rpop = rx_q.size() > 0 && rx_ready;
      chk("sb_avail", avail_to_router, rx_q.size() < DEPTH);
      chk("sb_rx_valid", rx_valid, rx_q.size() > 0);
      if (rx_q.size() > 0) chk("sb_rx_head", {rx_src_X, rx_src_Y, rx_payload}, rx_q[0]);
      chk("sb_rx_count", rx_count, m_rx);
      chk("sb_misroute", misroute, m_mis);
      if (snd) begin
        void'(tx_q.pop_front());
        m_tx++;
      end
      if (tacc) tx_q.push_back({1'b1, tx_dest_X, tx_dest_Y, node_X, node_Y, tx_payload});
      if (rpop) void'(rx_q.pop_front());
      if (racc) begin
        rx_q.push_back({from_router[2*CS+1:4*CS], from_router[4*CS+1:PL-1]});
        m_rx++;
        if (from_router[1:CS] != node_X || from_router[CS+1:2*CS] != node_Y) m_mis = 1'b1;
      end
    end
  end

  typedef struct packed {
    logic v;
    logic [CS-1:0] dx, dy;
    logic [PW-1:0] pl;
    logic av, er, es;
  } vec_t;
  vec_t tv [10];

  initial begin
    tv[0] = '{1'b1, 2'd1, 2'd0, 23'h101, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 2'd2, 2'd3, 23'h102, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 2'd3, 2'd1, 23'h103, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 2'd0, 2'd2, 23'h104, 1'b0, 1'b1, 1'b0};
    tv[4] = '{1'b1, 2'd1, 2'd1, 23'h105, 1'b0, 1'b0, 1'b0};
    tv[5] = '{1'b0, 2'd0, 2'd0, 23'h0, 1'b1, 1'b0, 1'b1};
    tv[6] = '{1'b0, 2'd0, 2'd0, 23'h0, 1'b1, 1'b1, 1'b1};
    tv[7] = '{1'b0, 2'd0, 2'd0, 23'h0, 1'b1, 1'b1, 1'b1};
    tv[8] = '{1'b0, 2'd0, 2'd0, 23'h0, 1'b1, 1'b1, 1'b1};
    tv[9] = '{1'b0, 2'd0, 2'd0, 23'h0, 1'b1, 1'b1, 1'b0};
    mon = 1;
    repeat (2) step();
    rst = 1'b0;
    router_avail = 1'b1;
    #1;
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_avail", avail_to_router, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_to_router", to_router, '0);
    chk("rst_misroute", misroute, 1'b0);
    // Single message, one-cycle latency to the router
    tx_valid = 1'b1; tx_dest_X = 2'd2; tx_dest_Y = 2'd1; tx_payload = 23'h5A;
    step();
    tx_valid = 1'b0;
    #1;
    chk("t1_flit", to_router, {1'b1, 2'd2, 2'd1, 2'd0, 2'd0, 23'h5A});
    step();
    chk("t1_tx_count", tx_count, 16'd1);
    chk("t1_idle", to_router, '0);
    // TX backpressure and drain
    for (int i = 0; i < 10; i++) begin
      tx_valid = tv[i].v; tx_dest_X = tv[i].dx; tx_dest_Y = tv[i].dy;
      tx_payload = tv[i].pl; router_avail = tv[i].av;
      #1;
      chk($sformatf("tv%0d_tx_ready", i), tx_ready, tv[i].er);
      chk($sformatf("tv%0d_send", i), to_router[0], tv[i].es);
      step();
    end
    chk("tv_tx_count", tx_count, 16'd5);
    // RX fill with overflow drop, then drain
    node_X = 2'd1; node_Y = 2'd1;
    for (int i = 0; i < 5; i++) begin
      from_router = mk(2'd1, 2'd1, 2'(i), 2'd0, 23'(32'h200 + i));
      #1;
      chk($sformatf("rx%0d_avail", i), avail_to_router, i < 4);
      step();
    end
    from_router = '0;
    #1;
    chk("rx_count_drop", rx_count, 16'd4);
    rx_ready = 1'b1;
    repeat (4) step();
    rx_ready = 1'b0;
    #1;
    chk("rx_drained", rx_valid, 1'b0);
    // Concurrent push and pop at occupancy 2
    for (int i = 0; i < 12; i++) begin
      from_router = mk(2'd1, 2'd1, 2'd2, 2'd3, 23'(32'h300 + i));
      rx_ready = i >= 2;
      step();
    end
    from_router = '0;
    rx_ready = 1'b0;
    #1;
    chk("pp_rx_count", rx_count, 16'd16);
    rx_ready = 1'b1;
    step();
    chk("pp_occ_1", rx_valid, 1'b1);
    step();
    chk("pp_occ_0", rx_valid, 1'b0);
    rx_ready = 1'b0;
    // Misroute is sticky and the flit is still delivered
    node_X = 2'd1; node_Y = 2'd0;
    from_router = mk(2'd0, 2'd2, 2'd3, 2'd3, 23'h77);
    step();
    from_router = '0;
    #1;
    chk("mis_set", misroute, 1'b1);
    chk("mis_rx_valid", rx_valid, 1'b1);
    chk("mis_payload", rx_payload, 23'h77);
    chk("mis_src_x", rx_src_X, 2'd3);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    repeat (3) step();
    chk("mis_sticky", misroute, 1'b1);
    // Fill both directions, then reset mid-operation
    router_avail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_payload = 23'(32'h400 + i);
      from_router = mk(2'd1, 2'd0, 2'd0, 2'd1, 23'(32'h500 + i));
      step();
    end
    tx_valid = 1'b0;
    from_router = '0;
    #1;
    chk("full_tx_ready", tx_ready, 1'b0);
    chk("full_avail", avail_to_router, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    router_avail = 1'b1;
    #1;
    chk("rr_tx_ready", tx_ready, 1'b1);
    chk("rr_avail", avail_to_router, 1'b1);
    chk("rr_rx_valid", rx_valid, 1'b0);
    chk("rr_to_router", to_router, '0);
    chk("rr_tx_count", tx_count, 16'd0);
    chk("rr_rx_count", rx_count, 16'd0);
    chk("rr_misroute", misroute, 1'b0);
    // Counter wrap: 65535 sends, then one more
    node_X = 2'd0; node_Y = 2'd0;
    tx_valid = 1'b1; tx_dest_X = 2'd3; tx_dest_Y = 2'd2; tx_payload = 23'h1234;
    repeat (65535) step();
    tx_valid = 1'b0;
    step();
    chk("wrap_ffff", tx_count, 16'hFFFF);
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    chk("wrap_zero", tx_count, 16'd0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
